// File: rtl/aux_pkg.sv
// Shared AUX definitions used by the AUX reply receive path.
//   aux_reply_cmd_e    : reply command encoding carried in the reply header
//   aux_rx_state_e     : receive FSM states of the reply demux
//   AUX_MAX_DATA_BYTES : largest data payload accepted in one reply
package aux_pkg;

    typedef enum logic [1:0] {
        AUX_ACK   = 2'b00,
        AUX_NACK  = 2'b01,
        AUX_DEFER = 2'b10,
        AUX_RSVD  = 2'b11
    } aux_reply_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DATA  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } aux_rx_state_e;

    localparam int AUX_MAX_DATA_BYTES = 16;

endpackage

// File: rtl/aux_reply_demux.sv
// AUX reply demultiplexer.
// Takes reply bytes from the AUX RX deserializer, decodes the reply header
// and routes the data bytes to the native or the I2C-over-AUX reply sink,
// whichever has the outstanding transaction. Malformed replies (reserved
// command, payload overflow, empty reply) are flagged at the end of the reply.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   phy_rx_byte / phy_rx_vld    received byte and its one-cycle valid
//   phy_rx_end                  end-of-reply pulse (STOP detected)
//   ctrl_i2c_native             1 = I2C transaction outstanding, 0 = native
//   native_reply_cmd[_vld]      decoded native reply command and strobe
//   native_reply_data[_vld]     native data byte and strobe
//   i2c_reply_cmd[_vld]         decoded I2C reply command and strobe
//   i2c_reply_data[_vld]        I2C data byte and strobe
//   reply_byte_cnt              data bytes forwarded in current/last reply
//   reply_done / reply_err      end-of-reply strobe and malformed flag
//   dbg_state                   current receive FSM state (observation only)
//
// Handshake: the PHY side is push-only. A byte is taken in every cycle
// phy_rx_vld is high; there is no backpressure. All output strobes are
// single-cycle pulses that the sinks must accept when they appear.
module aux_reply_demux
    import aux_pkg::*;
#(
    parameter int MAX_DATA_BYTES = AUX_MAX_DATA_BYTES
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    phy_rx_byte,
    input  logic          phy_rx_vld,
    input  logic          phy_rx_end,
    input  logic          ctrl_i2c_native,
    output logic [1:0]    native_reply_cmd,
    output logic          native_reply_cmd_vld,
    output logic [7:0]    native_reply_data,
    output logic          native_reply_data_vld,
    output logic [1:0]    i2c_reply_cmd,
    output logic          i2c_reply_cmd_vld,
    output logic [7:0]    i2c_reply_data,
    output logic          i2c_reply_data_vld,
    output logic [4:0]    reply_byte_cnt,
    output logic          reply_done,
    output logic          reply_err,
    output aux_rx_state_e dbg_state
);

    localparam logic [4:0] MAX_CNT = 5'(MAX_DATA_BYTES);

    // Native replies carry the command in [5:4], I2C replies in [7:6].
    function automatic aux_reply_cmd_e hdr_field(input logic [7:0] b, input logic sel);
        return aux_reply_cmd_e'(sel ? b[7:6] : b[5:4]);
    endfunction

    aux_rx_state_e  state_q, state_d;
    logic           sel_q, sel_d;
    logic           err_pend_q, err_pend_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [1:0]     ncmd_q, ncmd_d;
    logic           ncmd_vld_q, ncmd_vld_d;
    logic [7:0]     ndata_q, ndata_d;
    logic           ndata_vld_q, ndata_vld_d;
    logic [1:0]     icmd_q, icmd_d;
    logic           icmd_vld_q, icmd_vld_d;
    logic [7:0]     idata_q, idata_d;
    logic           idata_vld_q, idata_vld_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    aux_reply_cmd_e hdr_cmd;
    assign hdr_cmd = hdr_field(phy_rx_byte, ctrl_i2c_native);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        err_pend_d  = err_pend_q;
        cnt_d       = cnt_q;
        ncmd_d      = ncmd_q;
        ncmd_vld_d  = 1'b0;
        ndata_d     = ndata_q;
        ndata_vld_d = 1'b0;
        icmd_d      = icmd_q;
        icmd_vld_d  = 1'b0;
        idata_d     = idata_q;
        idata_vld_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (phy_rx_vld) begin
                    sel_d = ctrl_i2c_native;
                    cnt_d = '0;
                    if (hdr_cmd == AUX_RSVD) begin
                        err_pend_d = 1'b1;
                        state_d    = ST_DRAIN;
                    end else begin
                        if (ctrl_i2c_native) begin
                            icmd_d     = hdr_cmd;
                            icmd_vld_d = 1'b1;
                        end else begin
                            ncmd_d     = hdr_cmd;
                            ncmd_vld_d = 1'b1;
                        end
                        state_d = ST_DATA;
                    end
                    // Header and STOP together: reply with no payload.
                    if (phy_rx_end) begin
                        state_d = ST_DONE;
                    end
                end else if (phy_rx_end) begin
                    // STOP without any header byte: empty reply.
                    err_pend_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_DONE;
                end
            end
            ST_DATA: begin
                if (phy_rx_vld) begin
                    if (cnt_q == MAX_CNT) begin
                        err_pend_d = 1'b1;
                        state_d    = ST_DRAIN;
                    end else begin
                        if (sel_q) begin
                            idata_d     = phy_rx_byte;
                            idata_vld_d = 1'b1;
                        end else begin
                            ndata_d     = phy_rx_byte;
                            ndata_vld_d = 1'b1;
                        end
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                // The byte of this cycle has already been handled above.
                if (phy_rx_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (phy_rx_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                err_pend_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // reply_done/reply_err are registered alongside the DONE state so
        // they are visible during the DONE cycle itself.
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            done_d = 1'b1;
            err_d  = err_pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            err_pend_q  <= 1'b0;
            cnt_q       <= '0;
            ncmd_q      <= '0;
            ncmd_vld_q  <= 1'b0;
            ndata_q     <= '0;
            ndata_vld_q <= 1'b0;
            icmd_q      <= '0;
            icmd_vld_q  <= 1'b0;
            idata_q     <= '0;
            idata_vld_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            err_pend_q  <= err_pend_d;
            cnt_q       <= cnt_d;
            ncmd_q      <= ncmd_d;
            ncmd_vld_q  <= ncmd_vld_d;
            ndata_q     <= ndata_d;
            ndata_vld_q <= ndata_vld_d;
            icmd_q      <= icmd_d;
            icmd_vld_q  <= icmd_vld_d;
            idata_q     <= idata_d;
            idata_vld_q <= idata_vld_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign native_reply_cmd      = ncmd_q;
    assign native_reply_cmd_vld  = ncmd_vld_q;
    assign native_reply_data     = ndata_q;
    assign native_reply_data_vld = ndata_vld_q;
    assign i2c_reply_cmd         = icmd_q;
    assign i2c_reply_cmd_vld     = icmd_vld_q;
    assign i2c_reply_data        = idata_q;
    assign i2c_reply_data_vld    = idata_vld_q;
    assign reply_byte_cnt        = cnt_q;
    assign reply_done            = done_q;
    assign reply_err             = err_q;
    assign dbg_state             = state_q;

endmodule

// File: tb/tb_aux_reply_demux.sv
// Bench for aux_reply_demux: whole replies are described at transaction
// level (path, header, payload length, how the reply ends) and the expected
// output events are scheduled per cycle from the reply rules. One process
// compares every output against that schedule on every cycle.
module tb_aux_reply_demux;
    import aux_pkg::*;

    localparam int MAXB  = 16;
    localparam int NCYC  = 4096;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    phy_rx_byte;
    logic          phy_rx_vld;
    logic          phy_rx_end;
    logic          ctrl_i2c_native;
    logic [1:0]    native_reply_cmd;
    logic          native_reply_cmd_vld;
    logic [7:0]    native_reply_data;
    logic          native_reply_data_vld;
    logic [1:0]    i2c_reply_cmd;
    logic          i2c_reply_cmd_vld;
    logic [7:0]    i2c_reply_data;
    logic          i2c_reply_data_vld;
    logic [4:0]    reply_byte_cnt;
    logic          reply_done;
    logic          reply_err;
    aux_rx_state_e dbg_state;

    aux_reply_demux #(.MAX_DATA_BYTES(MAXB)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .phy_rx_byte          (phy_rx_byte),
        .phy_rx_vld           (phy_rx_vld),
        .phy_rx_end           (phy_rx_end),
        .ctrl_i2c_native      (ctrl_i2c_native),
        .native_reply_cmd     (native_reply_cmd),
        .native_reply_cmd_vld (native_reply_cmd_vld),
        .native_reply_data    (native_reply_data),
        .native_reply_data_vld(native_reply_data_vld),
        .i2c_reply_cmd        (i2c_reply_cmd),
        .i2c_reply_cmd_vld    (i2c_reply_cmd_vld),
        .i2c_reply_data       (i2c_reply_data),
        .i2c_reply_data_vld   (i2c_reply_data_vld),
        .reply_byte_cnt       (reply_byte_cnt),
        .reply_done           (reply_done),
        .reply_err            (reply_err),
        .dbg_state            (dbg_state)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    int  cyc = 0;
    bit  rst_at_edge = 1'b0;
    bit  chk_en = 1'b0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= !rst_n;
        chk_en      <= 1'b1;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit       ncv; bit [1:0] nc; bit ndv; bit [7:0] nd;
        bit       icv; bit [1:0] ic; bit idv; bit [7:0] id;
        bit       cs;  bit [4:0] cv; bit done; bit err;
    } ev_t;

    ev_t ev[NCYC];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Bus values the sinks should currently see (they hold between strobes).
    bit [1:0] r_nc, r_ic;
    bit [7:0] r_nd, r_id;
    bit [4:0] r_cnt;
    ev_t      e;

    always @(negedge clk) begin
        if (chk_en) begin
            e = ev[cyc];
            if (rst_at_edge) begin
                e = '{default: 0};
                r_nc = 0; r_ic = 0; r_nd = 0; r_id = 0; r_cnt = 0;
            end else begin
                if (e.ncv) r_nc  = e.nc;
                if (e.ndv) r_nd  = e.nd;
                if (e.icv) r_ic  = e.ic;
                if (e.idv) r_id  = e.id;
                if (e.cs)  r_cnt = e.cv;
            end
            chk("native_cmd_vld",  32'(native_reply_cmd_vld),  32'(e.ncv));
            chk("native_cmd",      32'(native_reply_cmd),      32'(r_nc));
            chk("native_data_vld", 32'(native_reply_data_vld), 32'(e.ndv));
            chk("native_data",     32'(native_reply_data),     32'(r_nd));
            chk("i2c_cmd_vld",     32'(i2c_reply_cmd_vld),     32'(e.icv));
            chk("i2c_cmd",         32'(i2c_reply_cmd),         32'(r_ic));
            chk("i2c_data_vld",    32'(i2c_reply_data_vld),    32'(e.idv));
            chk("i2c_data",        32'(i2c_reply_data),        32'(r_id));
            chk("byte_cnt",        32'(reply_byte_cnt),        32'(r_cnt));
            chk("reply_done",      32'(reply_done),            32'(e.done));
            chk("reply_err",       32'(reply_err),             32'(e.err));
        end
    end

    // Independent strobe counters, used for the literal per-test checks.
    int n_ncmd = 0, n_ndata = 0, n_icmd = 0, n_idata = 0, n_done = 0, n_err = 0;
    always @(negedge clk) begin
        n_ncmd  <= n_ncmd  + int'(native_reply_cmd_vld === 1'b1);
        n_ndata <= n_ndata + int'(native_reply_data_vld === 1'b1);
        n_icmd  <= n_icmd  + int'(i2c_reply_cmd_vld === 1'b1);
        n_idata <= n_idata + int'(i2c_reply_data_vld === 1'b1);
        n_done  <= n_done  + int'(reply_done === 1'b1);
        n_err   <= n_err   + int'(reply_err === 1'b1);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        phy_rx_vld = 1'b0;
        phy_rx_end = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // One reply: header on path 'sel', 'n' payload bytes base, base+1, ...
    // end_last puts STOP in the same cycle as the last byte; abort pulls
    // reset instead of sending STOP. ctrl_i2c_native is inverted after the
    // header in every reply, since only the header cycle may sample it.
    task automatic send_reply(input bit sel, input bit [7:0] hdr, input int n,
                              input bit [7:0] base, input bit end_last, input bit abort);
        bit [1:0] cmd;
        bit       err;
        int       k;
        int       k_end;
        cmd   = sel ? hdr[7:6] : hdr[5:4];
        err   = (cmd == 2'b11) || (n > MAXB);
        k_end = -1;

        k = cyc;
        ctrl_i2c_native = sel;
        phy_rx_byte     = hdr;
        phy_rx_vld      = 1'b1;
        phy_rx_end      = end_last && (n == 0) && !abort;
        ev[k+1].cs = 1; ev[k+1].cv = 0;
        if (cmd != 2'b11) begin
            if (sel) begin ev[k+1].icv = 1; ev[k+1].ic = cmd; end
            else     begin ev[k+1].ncv = 1; ev[k+1].nc = cmd; end
        end
        if (phy_rx_end) k_end = k;
        step();

        ctrl_i2c_native = ~sel;
        for (int i = 0; i < n; i++) begin
            k = cyc;
            phy_rx_byte = base + 8'(i);
            phy_rx_vld  = 1'b1;
            phy_rx_end  = end_last && (i == n - 1) && !abort;
            if (cmd != 2'b11 && i < MAXB) begin
                if (sel) begin ev[k+1].idv = 1; ev[k+1].id = phy_rx_byte; end
                else     begin ev[k+1].ndv = 1; ev[k+1].nd = phy_rx_byte; end
                ev[k+1].cs = 1; ev[k+1].cv = 5'(i + 1);
            end
            if (phy_rx_end) k_end = cyc;
            step();
        end

        if (abort) begin
            phy_rx_vld = 1'b0;
            phy_rx_end = 1'b0;
            rst_n      = 1'b0;
            step();
            rst_n      = 1'b1;
        end else begin
            if (k_end < 0) begin
                k_end      = cyc;
                phy_rx_vld = 1'b0;
                phy_rx_end = 1'b1;
                step();
            end
            ev[k_end+1].done = 1;
            ev[k_end+1].err  = err;
        end
        idle(2);
    endtask

    task automatic send_empty();
        int k;
        k = cyc;
        phy_rx_vld = 1'b0;
        phy_rx_end = 1'b1;
        ev[k+1].done = 1; ev[k+1].err = 1;
        ev[k+1].cs = 1;   ev[k+1].cv = 0;
        step();
        idle(2);
    endtask

    // ---------------- stimulus ----------------
    int b_ncmd, b_ndata, b_icmd, b_idata, b_done, b_err;

    task automatic snap();
        b_ncmd = n_ncmd; b_ndata = n_ndata; b_icmd = n_icmd;
        b_idata = n_idata; b_done = n_done; b_err = n_err;
    endtask

    initial begin
        rst_n           = 1'b0;
        phy_rx_byte     = 8'h00;
        phy_rx_vld      = 1'b0;
        phy_rx_end      = 1'b0;
        ctrl_i2c_native = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        idle(2);

        // Native ACK with two data bytes.
        snap();
        send_reply(1'b0, 8'h00, 2, 8'hA5, 1'b0, 1'b0);
        // second byte is A5+1 = A6; use the literal values to pin the model
        chk("t1_cnt",        32'(reply_byte_cnt), 32'd2);
        chk("t1_last_data",  32'(native_reply_data), 32'hA6);
        chk("t1_ndata_n",    32'(n_ndata - b_ndata), 32'd2);
        chk("t1_i2c_quiet",  32'(n_icmd + n_idata - b_icmd - b_idata), 32'd0);
        chk("t1_done_err",   32'((n_done - b_done) * 16 + (n_err - b_err)), 32'h10);

        // Native ACK with the exact 0xA5,0x5A payload, STOP with the last byte.
        snap();
        phy_rx_byte = 8'h00; ctrl_i2c_native = 1'b0; phy_rx_vld = 1'b1; phy_rx_end = 1'b0;
        begin
            int k; k = cyc;
            ev[k+1].ncv = 1; ev[k+1].nc = 2'b00; ev[k+1].cs = 1; ev[k+1].cv = 0;
            step();
            k = cyc; phy_rx_byte = 8'hA5;
            ev[k+1].ndv = 1; ev[k+1].nd = 8'hA5; ev[k+1].cs = 1; ev[k+1].cv = 1;
            step();
            k = cyc; phy_rx_byte = 8'h5A; phy_rx_end = 1'b1;
            ev[k+1].ndv = 1; ev[k+1].nd = 8'h5A; ev[k+1].cs = 1; ev[k+1].cv = 2;
            ev[k+1].done = 1; ev[k+1].err = 0;
            step();
            idle(2);
        end
        chk("t1b_last_data", 32'(native_reply_data), 32'h5A);
        chk("t1b_done",      32'(n_done - b_done), 32'd1);

        // I2C DEFER header alone.
        snap();
        send_reply(1'b1, 8'h80, 0, 8'h00, 1'b0, 1'b0);
        chk("t2_i2c_cmd",  32'(i2c_reply_cmd), 32'h2);
        chk("t2_cnt",      32'(reply_byte_cnt), 32'd0);
        chk("t2_err_n",    32'(n_err - b_err), 32'd0);
        chk("t2_native",   32'(n_ncmd - b_ncmd), 32'd0);

        // Native reserved command: drained and flagged.
        snap();
        send_reply(1'b0, 8'h30, 3, 8'h11, 1'b0, 1'b0);
        chk("t3_err_n",    32'(n_err - b_err), 32'd1);
        chk("t3_no_cmd",   32'(n_ncmd + n_icmd - b_ncmd - b_icmd), 32'd0);
        chk("t3_no_data",  32'(n_ndata + n_idata - b_ndata - b_idata), 32'd0);

        // I2C ACK with 18 data bytes: only 16 forwarded.
        snap();
        send_reply(1'b1, 8'h00, 18, 8'h00, 1'b0, 1'b0);
        chk("t4_idata_n",  32'(n_idata - b_idata), 32'd16);
        chk("t4_cnt",      32'(reply_byte_cnt), 32'd16);
        chk("t4_last",     32'(i2c_reply_data), 32'h0F);
        chk("t4_err_n",    32'(n_err - b_err), 32'd1);

        // Boundary: exactly 16 bytes is legal; low header nibble ignored.
        snap();
        send_reply(1'b0, 8'h0F, 16, 8'h40, 1'b1, 1'b0);
        chk("t4b_err_n",   32'(n_err - b_err), 32'd0);
        chk("t4b_cnt",     32'(reply_byte_cnt), 32'd16);

        // 17th byte arrives together with STOP: dropped and flagged.
        send_reply(1'b1, 8'h40, 17, 8'h80, 1'b1, 1'b0);

        // Empty reply.
        snap();
        send_empty();
        chk("t5_done_err", 32'((n_done - b_done) * 16 + (n_err - b_err)), 32'h11);
        chk("t5_cnt",      32'(reply_byte_cnt), 32'd0);

        // Native DEFER, STOP on the last byte.
        send_reply(1'b0, 8'h20, 2, 8'hC3, 1'b1, 1'b0);

        // Native NACK, ctrl flips, reset mid-payload.
        snap();
        send_reply(1'b0, 8'h10, 3, 8'h77, 1'b0, 1'b1);
        chk("t6_ndata_n",  32'(n_ndata - b_ndata), 32'd3);
        chk("t6_i2c_quiet",32'(n_icmd + n_idata - b_icmd - b_idata), 32'd0);
        chk("t6_no_done",  32'(n_done - b_done), 32'd0);
        chk("t6_data_rst", 32'(native_reply_data), 32'h00);
        chk("t6_cmd_rst",  32'(native_reply_cmd), 32'h0);

        // A clean reply after the reset still works.
        send_reply(1'b1, 8'h40, 1, 8'h5C, 1'b0, 1'b0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
